// File: rtl/hspi_tx_pattern_src.sv
// HSPI transmit packet source: fills a packet buffer with a channel header and a payload
// pattern, starts the engine, waits for completion or timeout, and repeats at a fixed period.
module hspi_tx_pattern_src #(
   parameter int DATA_W  = 32,
   parameter int ADDR_W  = 9,
   parameter int PKT_LEN = 512,
   parameter int PERIOD  = 2097152,
   parameter int NUM_CH  = 4,
   parameter int TIMEOUT = 65536
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              enable,
   input  logic [1:0]        mode,
   input  logic [31:0]       seed,
   output logic              tx_act,
   input  logic              tx_done,
   input  logic [ADDR_W-1:0] ram_addr,
   output logic [DATA_W-1:0] ram_rdata,
   output logic              busy,
   output logic [31:0]       pkt_cnt,
   output logic [15:0]       err_cnt
);

   // state         | meaning
   // S_IDLE        | generator stopped, waiting for enable
   // S_FILL        | writing header + payload, one word per cycle
   // S_SEND        | single-cycle tx_act pulse to the engine
   // S_WAIT_DONE   | waiting for tx_done, bounded by the timeout down-counter
   // S_WAIT_PERIOD | holding off until the period counter reaches its terminal count
   typedef enum logic [2:0] {
      S_IDLE,
      S_FILL,
      S_SEND,
      S_WAIT_DONE,
      S_WAIT_PERIOD
   } state_t;

   localparam int PER_W = (PERIOD > 1) ? $clog2(PERIOD) : 1;
   localparam int TO_W  = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
   localparam int CH_W  = (NUM_CH > 1) ? $clog2(NUM_CH) : 1;

   localparam logic [ADDR_W-1:0] K_LAST    = ADDR_W'(PKT_LEN - 1);
   localparam logic [PER_W-1:0]  PER_LAST  = PER_W'(PERIOD - 1);
   localparam logic [TO_W-1:0]   TO_LAST   = TO_W'(TIMEOUT - 1);
   localparam logic [CH_W-1:0]   CH_LAST   = CH_W'(NUM_CH - 1);
   localparam logic [31:0]       LFSR_TAPS = 32'h8020_0003;

   state_t              state_q, state_d;
   logic [ADDR_W-1:0]   k_q, k_d;
   logic [PER_W-1:0]    per_q, per_d;
   logic [TO_W-1:0]     to_q, to_d;
   logic [1:0]          mode_q, mode_d;
   logic [31:0]         pat_q, pat_d;
   logic [CH_W-1:0]     ch_q, ch_d;
   logic [15:0]         seq_q [NUM_CH];
   logic [15:0]         seq_d [NUM_CH];
   logic [31:0]         pkt_q, pkt_d;
   logic [15:0]         err_q, err_d;
   logic [DATA_W-1:0]   rdata_q;
   logic [DATA_W-1:0]   mem_q [2**ADDR_W];
   logic                mem_we;
   logic [DATA_W-1:0]   mem_wdata;
   logic                fill_start;

   // pat_q always holds the payload word for the next fill index
   function automatic logic [31:0] pat_init(input logic [1:0] m, input logic [31:0] s);
      case (m)
         2'b01:   pat_init = (s == 32'h0) ? 32'h1 : s;
         2'b10:   pat_init = 32'h1;
         default: pat_init = s;
      endcase
   endfunction

   function automatic logic [31:0] pat_next(input logic [1:0] m, input logic [31:0] w);
      case (m)
         2'b00:   pat_next = w + 32'd1;
         2'b01:   pat_next = (w >> 1) ^ (w[0] ? LFSR_TAPS : 32'h0);
         2'b10:   pat_next = {w[30:0], w[31]};
         default: pat_next = w;
      endcase
   endfunction

   always_comb begin
      state_d    = state_q;
      k_d        = k_q;
      per_d      = per_q;
      to_d       = to_q;
      mode_d     = mode_q;
      pat_d      = pat_q;
      ch_d       = ch_q;
      seq_d      = seq_q;
      pkt_d      = pkt_q;
      err_d      = err_q;
      mem_we     = 1'b0;
      mem_wdata  = '0;
      fill_start = 1'b0;

      if (per_q != PER_LAST) per_d = per_q + 1'b1;

      case (state_q)
         S_IDLE: begin
            if (enable) fill_start = 1'b1;
         end
         S_FILL: begin
            mem_we = ~rst;
            if (k_q == '0) begin
               mem_wdata = {8'hA5, 8'(ch_q), seq_q[ch_q]};
            end else begin
               mem_wdata = pat_q;
               pat_d     = pat_next(mode_q, pat_q);
            end
            if (k_q == K_LAST) state_d = S_SEND;
            else               k_d     = k_q + 1'b1;
         end
         S_SEND: begin
            to_d    = TO_LAST;
            state_d = S_WAIT_DONE;
         end
         S_WAIT_DONE: begin
            // tx_done on the expiry cycle counts as a clean completion
            if (tx_done || to_q == '0) begin
               pkt_d        = pkt_q + 32'd1;
               if (!tx_done && err_q != 16'hFFFF) err_d = err_q + 16'd1;
               seq_d[ch_q]  = seq_q[ch_q] + 16'd1;
               ch_d         = (ch_q == CH_LAST) ? '0 : ch_q + 1'b1;
               state_d      = S_WAIT_PERIOD;
            end else begin
               to_d = to_q - 1'b1;
            end
         end
         S_WAIT_PERIOD: begin
            if (!enable)                fill_start = 1'b0;
            else if (per_q == PER_LAST) fill_start = 1'b1;
            if (!enable) state_d = S_IDLE;
         end
         default: state_d = S_IDLE;
      endcase

      if (fill_start) begin
         state_d = S_FILL;
         k_d     = '0;
         per_d   = '0;
         mode_d  = mode;
         pat_d   = pat_init(mode, seed);
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q <= S_IDLE;
         k_q     <= '0;
         per_q   <= '0;
         to_q    <= '0;
         mode_q  <= '0;
         pat_q   <= '0;
         ch_q    <= '0;
         pkt_q   <= '0;
         err_q   <= '0;
         rdata_q <= '0;
         for (int i = 0; i < NUM_CH; i++) seq_q[i] <= '0;
      end else begin
         state_q <= state_d;
         k_q     <= k_d;
         per_q   <= per_d;
         to_q    <= to_d;
         mode_q  <= mode_d;
         pat_q   <= pat_d;
         ch_q    <= ch_d;
         pkt_q   <= pkt_d;
         err_q   <= err_d;
         rdata_q <= mem_q[ram_addr];
         for (int i = 0; i < NUM_CH; i++) seq_q[i] <= seq_d[i];
      end
   end

   // buffer contents deliberately survive reset
   always_ff @(posedge clk) begin
      if (mem_we) mem_q[k_q] <= mem_wdata;
   end

   assign tx_act    = (state_q == S_SEND);
   assign busy      = (state_q != S_IDLE);
   assign ram_rdata = rdata_q;
   assign pkt_cnt   = pkt_q;
   assign err_cnt   = err_q;

endmodule

// File: tb/tb_hspi_tx_pattern_src.sv
// Self-checking bench for hspi_tx_pattern_src: randomized patterns checked against a
// packet-level reference model built from the header/payload rules.
module tb_hspi_tx_pattern_src;

   localparam int DATA_W  = 32;
   localparam int ADDR_W  = 9;
   localparam int PKT_LEN = 8;
   localparam int PERIOD  = 32;
   localparam int NUM_CH  = 2;
   localparam int TIMEOUT = 64;

   logic              clk;
   logic              rst;
   logic              enable;
   logic [1:0]        mode;
   logic [31:0]       seed;
   logic              tx_act;
   logic              tx_done;
   logic [ADDR_W-1:0] ram_addr;
   logic [DATA_W-1:0] ram_rdata;
   logic              busy;
   logic [31:0]       pkt_cnt;
   logic [15:0]       err_cnt;

   int n_cmp = 0;
   int n_err = 0;
   int cyc   = 0;

   int          mdl_ch;
   int          mdl_seq [NUM_CH];
   int          mdl_pkt;
   int          mdl_err;
   logic [1:0]  pkt_mode;
   logic [31:0] pkt_seed;
   logic [31:0] rd_words [PKT_LEN];

   hspi_tx_pattern_src #(
      .DATA_W (DATA_W),
      .ADDR_W (ADDR_W),
      .PKT_LEN(PKT_LEN),
      .PERIOD (PERIOD),
      .NUM_CH (NUM_CH),
      .TIMEOUT(TIMEOUT)
   ) dut (
      .clk      (clk),
      .rst      (rst),
      .enable   (enable),
      .mode     (mode),
      .seed     (seed),
      .tx_act   (tx_act),
      .tx_done  (tx_done),
      .ram_addr (ram_addr),
      .ram_rdata(ram_rdata),
      .busy     (busy),
      .pkt_cnt  (pkt_cnt),
      .err_cnt  (err_cnt)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   initial begin
      #200000;
      $display("FAIL watchdog: simulation did not finish, compared=%0d", n_cmp);
      $fatal(1, "watchdog");
   end

   // expected buffer word k of a packet, straight from the header/payload rules
   function automatic logic [31:0] exp_word(input logic [1:0] m, input logic [31:0] s,
                                            input int ch, input int sq, input int k);
      logic [31:0] w;
      if (k == 0) return {8'hA5, 8'(ch), 16'(sq)};
      case (m)
         2'b00: return s + 32'(k - 1);
         2'b01: begin
            w = (s == 32'h0) ? 32'h1 : s;
            for (int i = 1; i < k; i++) w = (w >> 1) ^ (w[0] ? 32'h8020_0003 : 32'h0);
            return w;
         end
         2'b10: return 32'h1 << ((k - 1) % 32);
         default: return s;
      endcase
   endfunction

   task automatic step();
      @(posedge clk);
      #1;
      cyc++;
   endtask

   task automatic model_reset();
      mdl_ch  = 0;
      mdl_pkt = 0;
      mdl_err = 0;
      for (int i = 0; i < NUM_CH; i++) mdl_seq[i] = 0;
   endtask

   task automatic model_complete(input bit timed_out);
      mdl_seq[mdl_ch] = (mdl_seq[mdl_ch] + 1) % 65536;
      mdl_ch          = (mdl_ch + 1) % NUM_CH;
      mdl_pkt++;
      if (timed_out && mdl_err < 65535) mdl_err++;
   endtask

   task automatic do_reset();
      rst      = 1'b1;
      enable   = 1'b0;
      tx_done  = 1'b0;
      ram_addr = '0;
      step();
      step();
      rst = 1'b0;
      model_reset();
   endtask

   task automatic wait_act(input int bound, output int n, output bit ok);
      n  = 0;
      ok = 1'b0;
      while (n < bound && !ok) begin
         step();
         n++;
         if (tx_act === 1'b1) ok = 1'b1;
      end
   endtask

   task automatic read_buf();
      for (int k = 0; k < PKT_LEN; k++) begin
         ram_addr = ADDR_W'(k);
         step();
         rd_words[k] = ram_rdata;
      end
   endtask

   task automatic test_reset();
      rst      = 1'b1;
      enable   = 1'b1;
      tx_done  = 1'b0;
      mode     = 2'b00;
      seed     = 32'h0;
      ram_addr = '0;
      step();
      step();
      step();
      n_cmp++; if (tx_act !== 1'b0)      begin n_err++; $display("FAIL reset_tx_act: got %b want 0", tx_act); end
      n_cmp++; if (busy !== 1'b0)        begin n_err++; $display("FAIL reset_busy: got %b want 0", busy); end
      n_cmp++; if (ram_rdata !== 32'h0)  begin n_err++; $display("FAIL reset_rdata: got %h want 0", ram_rdata); end
      n_cmp++; if (pkt_cnt !== 32'h0)    begin n_err++; $display("FAIL reset_pkt_cnt: got %0d want 0", pkt_cnt); end
      n_cmp++; if (err_cnt !== 16'h0)    begin n_err++; $display("FAIL reset_err_cnt: got %0d want 0", err_cnt); end
      rst    = 1'b0;
      enable = 1'b0;
      step();
   endtask

   task automatic test_ramp();
      do_reset();
      mode     = 2'b00;
      seed     = 32'h0000_0100;
      pkt_mode = mode;
      pkt_seed = seed;
      enable   = 1'b1;
      for (int c = 1; c <= 10; c++) begin
         step();
         n_cmp++;
         if (tx_act !== (c == 9)) begin
            n_err++; $display("FAIL ramp_tx_act cycle %0d: got %b want %b", c, tx_act, (c == 9));
         end
         if (c == 1) begin
            n_cmp++; if (busy !== 1'b1) begin n_err++; $display("FAIL ramp_busy: got %b want 1", busy); end
         end
      end
      ram_addr = 9'd0;
      step();
      n_cmp++; if (ram_rdata !== 32'hA500_0000) begin n_err++; $display("FAIL ramp_addr0: got %h want a5000000", ram_rdata); end
      ram_addr = 9'd3;
      step();
      n_cmp++; if (ram_rdata !== 32'h0000_0102) begin n_err++; $display("FAIL ramp_addr3: got %h want 00000102", ram_rdata); end
      read_buf();
      for (int k = 0; k < PKT_LEN; k++) begin
         n_cmp++;
         if (rd_words[k] !== exp_word(pkt_mode, pkt_seed, mdl_ch, mdl_seq[mdl_ch], k)) begin
            n_err++; $display("FAIL ramp_word%0d: got %h want %h", k, rd_words[k],
                              exp_word(pkt_mode, pkt_seed, mdl_ch, mdl_seq[mdl_ch], k));
         end
      end
      enable  = 1'b0;
      tx_done = 1'b1;
      step();
      tx_done = 1'b0;
      model_complete(1'b0);
      n_cmp++; if (pkt_cnt !== 32'(mdl_pkt)) begin n_err++; $display("FAIL ramp_pkt_cnt: got %0d want %0d", pkt_cnt, mdl_pkt); end
      step();
   endtask

   task automatic test_rotation();
      int  n, t_act, t_prev;
      bit  ok;
      do_reset();
      mode     = 2'($urandom_range(0, 3));
      seed     = $urandom;
      pkt_mode = mode;
      pkt_seed = seed;
      enable   = 1'b1;
      t_prev   = 0;
      for (int p = 0; p < 4; p++) begin
         wait_act(60, n, ok);
         n_cmp++;
         if (!ok) begin
            n_err++; $display("FAIL rot_tx_act_timeout pkt%0d: got none want pulse", p);
         end
         t_act = cyc;
         if (p > 0) begin
            n_cmp++;
            if (t_act - t_prev != PERIOD) begin
               n_err++; $display("FAIL rot_spacing pkt%0d: got %0d want %0d", p, t_act - t_prev, PERIOD);
            end
         end
         t_prev = t_act;
         for (int i = 0; i < 5; i++) step();
         tx_done = 1'b1;
         step();
         tx_done = 1'b0;
         read_buf();
         for (int k = 0; k < PKT_LEN; k++) begin
            n_cmp++;
            if (rd_words[k] !== exp_word(pkt_mode, pkt_seed, mdl_ch, mdl_seq[mdl_ch], k)) begin
               n_err++; $display("FAIL rot_word%0d pkt%0d: got %h want %h", k, p, rd_words[k],
                                 exp_word(pkt_mode, pkt_seed, mdl_ch, mdl_seq[mdl_ch], k));
            end
         end
         model_complete(1'b0);
         n_cmp++; if (pkt_cnt !== 32'(mdl_pkt)) begin n_err++; $display("FAIL rot_pkt_cnt pkt%0d: got %0d want %0d", p, pkt_cnt, mdl_pkt); end
         n_cmp++; if (err_cnt !== 16'h0)        begin n_err++; $display("FAIL rot_err_cnt pkt%0d: got %0d want 0", p, err_cnt); end
         mode     = 2'($urandom_range(0, 3));
         seed     = $urandom;
         pkt_mode = mode;
         pkt_seed = seed;
      end
      enable = 1'b0;
   endtask

   task automatic test_lfsr_walk();
      int  n;
      bit  ok;
      do_reset();
      mode     = 2'b01;
      seed     = 32'h0;
      pkt_mode = mode;
      pkt_seed = seed;
      enable   = 1'b1;
      wait_act(20, n, ok);
      n_cmp++; if (!ok) begin n_err++; $display("FAIL lfsr_tx_act_timeout: got none want pulse"); end
      read_buf();
      n_cmp++; if (rd_words[1] !== 32'h0000_0001) begin n_err++; $display("FAIL lfsr_w1: got %h want 00000001", rd_words[1]); end
      n_cmp++; if (rd_words[2] !== 32'h8020_0003) begin n_err++; $display("FAIL lfsr_w2: got %h want 80200003", rd_words[2]); end
      n_cmp++; if (rd_words[3] !== 32'hC030_0002) begin n_err++; $display("FAIL lfsr_w3: got %h want c0300002", rd_words[3]); end
      for (int k = 4; k < PKT_LEN; k++) begin
         n_cmp++;
         if (rd_words[k] !== exp_word(pkt_mode, pkt_seed, mdl_ch, mdl_seq[mdl_ch], k)) begin
            n_err++; $display("FAIL lfsr_word%0d: got %h want %h", k, rd_words[k],
                              exp_word(pkt_mode, pkt_seed, mdl_ch, mdl_seq[mdl_ch], k));
         end
      end
      tx_done = 1'b1;
      step();
      tx_done = 1'b0;
      model_complete(1'b0);
      mode     = 2'b10;
      seed     = $urandom;
      pkt_mode = mode;
      pkt_seed = seed;
      wait_act(60, n, ok);
      n_cmp++; if (!ok) begin n_err++; $display("FAIL walk_tx_act_timeout: got none want pulse"); end
      read_buf();
      n_cmp++; if (rd_words[7] !== 32'h0000_0040) begin n_err++; $display("FAIL walk_w7: got %h want 00000040", rd_words[7]); end
      for (int k = 0; k < PKT_LEN; k++) begin
         n_cmp++;
         if (rd_words[k] !== exp_word(pkt_mode, pkt_seed, mdl_ch, mdl_seq[mdl_ch], k)) begin
            n_err++; $display("FAIL walk_word%0d: got %h want %h", k, rd_words[k],
                              exp_word(pkt_mode, pkt_seed, mdl_ch, mdl_seq[mdl_ch], k));
         end
      end
      enable  = 1'b0;
      tx_done = 1'b1;
      step();
      tx_done = 1'b0;
      step();
   endtask

   task automatic test_timeout();
      int  n, t_act;
      bit  ok;
      do_reset();
      mode     = 2'($urandom_range(0, 3));
      seed     = $urandom;
      pkt_mode = mode;
      pkt_seed = seed;
      enable   = 1'b1;
      wait_act(20, n, ok);
      n_cmp++; if (!ok) begin n_err++; $display("FAIL to_tx_act_timeout: got none want pulse"); end
      t_act = cyc;
      read_buf();
      for (int k = 0; k < PKT_LEN; k++) begin
         n_cmp++;
         if (rd_words[k] !== exp_word(pkt_mode, pkt_seed, mdl_ch, mdl_seq[mdl_ch], k)) begin
            n_err++; $display("FAIL to_word%0d: got %h want %h", k, rd_words[k],
                              exp_word(pkt_mode, pkt_seed, mdl_ch, mdl_seq[mdl_ch], k));
         end
      end
      while (cyc < t_act + TIMEOUT) step();
      n_cmp++; if (err_cnt !== 16'h0) begin n_err++; $display("FAIL to_early_err: got %0d want 0", err_cnt); end
      n_cmp++; if (pkt_cnt !== 32'h0) begin n_err++; $display("FAIL to_early_pkt: got %0d want 0", pkt_cnt); end
      step();
      model_complete(1'b1);
      n_cmp++; if (err_cnt !== 16'(mdl_err)) begin n_err++; $display("FAIL to_err_cnt: got %0d want %0d", err_cnt, mdl_err); end
      n_cmp++; if (pkt_cnt !== 32'(mdl_pkt)) begin n_err++; $display("FAIL to_pkt_cnt: got %0d want %0d", pkt_cnt, mdl_pkt); end
      wait_act(20, n, ok);
      n_cmp++; if (!ok) begin n_err++; $display("FAIL to2_tx_act_timeout: got none want pulse"); end
      t_act    = cyc;
      ram_addr = 9'd0;
      step();
      n_cmp++;
      if (ram_rdata !== exp_word(pkt_mode, pkt_seed, mdl_ch, mdl_seq[mdl_ch], 0)) begin
         n_err++; $display("FAIL to_hdr_ch1: got %h want %h", ram_rdata,
                           exp_word(pkt_mode, pkt_seed, mdl_ch, mdl_seq[mdl_ch], 0));
      end
      while (cyc < t_act + TIMEOUT) step();
      tx_done = 1'b1;
      step();
      tx_done = 1'b0;
      model_complete(1'b0);
      n_cmp++; if (err_cnt !== 16'(mdl_err)) begin n_err++; $display("FAIL to_coincide_err: got %0d want %0d", err_cnt, mdl_err); end
      n_cmp++; if (pkt_cnt !== 32'(mdl_pkt)) begin n_err++; $display("FAIL to_coincide_pkt: got %0d want %0d", pkt_cnt, mdl_pkt); end
      enable = 1'b0;
      step();
   endtask

   task automatic test_enable_reset();
      int  n;
      bit  ok;
      do_reset();
      mode     = 2'($urandom_range(0, 3));
      seed     = $urandom;
      pkt_mode = mode;
      pkt_seed = seed;
      enable   = 1'b1;
      step();
      step();
      step();
      enable  = 1'b0;
      mode    = ~pkt_mode;
      seed    = ~pkt_seed;
      tx_done = 1'b1;
      step();
      tx_done = 1'b0;
      wait_act(20, n, ok);
      n_cmp++; if (!ok) begin n_err++; $display("FAIL en_tx_act_timeout: got none want pulse"); end
      read_buf();
      for (int k = 0; k < PKT_LEN; k++) begin
         n_cmp++;
         if (rd_words[k] !== exp_word(pkt_mode, pkt_seed, mdl_ch, mdl_seq[mdl_ch], k)) begin
            n_err++; $display("FAIL en_word%0d: got %h want %h", k, rd_words[k],
                              exp_word(pkt_mode, pkt_seed, mdl_ch, mdl_seq[mdl_ch], k));
         end
      end
      tx_done = 1'b1;
      step();
      tx_done = 1'b0;
      model_complete(1'b0);
      n_cmp++; if (busy !== 1'b1)            begin n_err++; $display("FAIL en_busy_wp: got %b want 1", busy); end
      n_cmp++; if (pkt_cnt !== 32'(mdl_pkt)) begin n_err++; $display("FAIL en_pkt_cnt: got %0d want %0d", pkt_cnt, mdl_pkt); end
      step();
      n_cmp++; if (busy !== 1'b0)            begin n_err++; $display("FAIL en_busy_idle: got %b want 0", busy); end

      enable = 1'b1;
      wait_act(20, n, ok);
      n_cmp++; if (!ok) begin n_err++; $display("FAIL rst_tx_act_timeout: got none want pulse"); end
      step();
      step();
      step();
      rst = 1'b1;
      step();
      rst = 1'b0;
      model_reset();
      n_cmp++; if (busy !== 1'b0)     begin n_err++; $display("FAIL rst_mid_busy: got %b want 0", busy); end
      n_cmp++; if (pkt_cnt !== 32'h0) begin n_err++; $display("FAIL rst_mid_pkt: got %0d want 0", pkt_cnt); end
      n_cmp++; if (tx_act !== 1'b0)   begin n_err++; $display("FAIL rst_mid_tx_act: got %b want 0", tx_act); end
      wait_act(20, n, ok);
      n_cmp++; if (!ok) begin n_err++; $display("FAIL rst2_tx_act_timeout: got none want pulse"); end
      ram_addr = 9'd0;
      step();
      n_cmp++; if (ram_rdata !== 32'hA500_0000) begin n_err++; $display("FAIL rst_restart_hdr: got %h want a5000000", ram_rdata); end
      enable  = 1'b0;
      tx_done = 1'b1;
      step();
      tx_done = 1'b0;
      step();
   endtask

   initial begin
      rst      = 1'b1;
      enable   = 1'b0;
      mode     = 2'b00;
      seed     = 32'h0;
      tx_done  = 1'b0;
      ram_addr = '0;
      model_reset();
      test_reset();
      test_ramp();
      test_rotation();
      test_lfsr_walk();
      test_timeout();
      test_enable_reset();
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule
